// File: rtl/tff_counter_seq.sv
// Toggle-input sequencer for a WIDTH-bit bank of T flip-flops: counts up/down to a target with pause/resume/clear.
// Optional TFF_PRESCALE_EN inserts a PRESCALE-cycle divider between count steps while running.
module tff_counter_seq #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic             cmd_dir,
   input  logic [WIDTH-1:0] cmd_target,
   output logic [WIDTH-1:0] t_en,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic             busy,
   output logic             done,
   output logic             wrap
);

   // state  | meaning
   // S_IDLE | waiting for START or CLEAR, q holds
   // S_RUN  | stepping toward target_r, one step per enabled cycle
   // S_PAUSE| stopped mid-count, q holds until RESUME/START/CLEAR
   // S_CLR  | one cycle, every set bit toggles so q returns to zero
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_CLR} state_t;

   localparam logic [1:0] OP_START  = 2'b00;
   localparam logic [1:0] OP_STOP   = 2'b01;
   localparam logic [1:0] OP_RESUME = 2'b10;
   localparam logic [1:0] OP_CLEAR  = 2'b11;
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   if (WIDTH < 2 || PRESCALE < 2) begin : g_param_check
      $error("tff_counter_seq: WIDTH and PRESCALE must both be >= 2");
   end

   state_t           state, state_d;
   logic [WIDTH-1:0] target_r, target_d;
   logic             dir_r, dir_d;
   logic             accept, stop_clr, step, at_target, enter_run;

   assign accept    = cmd_valid & cmd_ready;
   assign stop_clr  = accept & ((cmd_op == OP_STOP) | (cmd_op == OP_CLEAR));
   assign at_target = (q == target_r);

`ifdef TFF_PRESCALE_EN
   localparam int DIV_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   logic [DIV_W-1:0] div_cnt;
   logic             div_tc;

   assign div_tc = (div_cnt == DIV_W'(PRESCALE - 1));
   assign step   = (state == S_RUN) & ~at_target & ~stop_clr & div_tc;

   // Divider restarts whenever RUN is (re)entered or left, so every run starts a full period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (state_d != S_RUN || enter_run) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
      end
   end
`else
   assign step = (state == S_RUN) & ~at_target & ~stop_clr;
`endif

   assign cmd_ready = (state != S_CLR);
   assign busy      = (state == S_RUN);
   assign done      = (state == S_RUN) & at_target;
   assign wrap      = step & ((~dir_r & (q == ALL_ONES)) | (dir_r & (q == '0)));
   assign qn        = ~q;

   // Ripple enable: a bit toggles when all lower bits are 1 (up) or all 0 (down).
   always_comb begin : t_en_calc
      logic carry;
      t_en  = '0;
      carry = 1'b1;
      if (state == S_CLR) begin
         t_en = q;
      end else if (step) begin
         for (int i = 0; i < WIDTH; i++) begin
            t_en[i] = carry;
            carry   = carry & (dir_r ? ~q[i] : q[i]);
         end
      end
   end

   always_comb begin
      state_d   = state;
      target_d  = target_r;
      dir_d     = dir_r;
      enter_run = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (accept && cmd_op == OP_START) begin
               state_d   = S_RUN;
               target_d  = cmd_target;
               dir_d     = cmd_dir;
               enter_run = 1'b1;
            end else if (accept && cmd_op == OP_CLEAR) begin
               state_d = S_CLR;
            end
         end
         S_RUN: begin
            if (accept && cmd_op == OP_START) begin
               target_d = cmd_target;
               dir_d    = cmd_dir;
            end else if (accept && cmd_op == OP_STOP) begin
               state_d = S_PAUSE;
            end else if (accept && cmd_op == OP_CLEAR) begin
               state_d = S_CLR;
            end else if (at_target) begin
               state_d = S_IDLE;
            end
         end
         S_PAUSE: begin
            if (accept && cmd_op == OP_START) begin
               state_d   = S_RUN;
               target_d  = cmd_target;
               dir_d     = cmd_dir;
               enter_run = 1'b1;
            end else if (accept && cmd_op == OP_RESUME) begin
               state_d   = S_RUN;
               enter_run = 1'b1;
            end else if (accept && cmd_op == OP_CLEAR) begin
               state_d = S_CLR;
            end
         end
         S_CLR: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         q        <= '0;
         target_r <= '0;
         dir_r    <= 1'b0;
      end else begin
         state    <= state_d;
         q        <= q ^ t_en;
         target_r <= target_d;
         dir_r    <= dir_d;
      end
   end

endmodule

// File: tb/tb_tff_counter_seq.sv
// Directed bench for tff_counter_seq (WIDTH=4); the prescale scenario runs when TFF_PRESCALE_EN is defined.
module tb_tff_counter_seq;
   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic             cmd_dir;
   logic [WIDTH-1:0] cmd_target;
   logic [WIDTH-1:0] t_en, q, qn;
   logic             busy, done, wrap;

   int n_assert = 0;
   int n_fail   = 0;

   tff_counter_seq #(.WIDTH(WIDTH), .PRESCALE(4)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_target(cmd_target),
      .t_en(t_en), .q(q), .qn(qn), .busy(busy), .done(done), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // Presents one command for exactly one edge, then lets outputs settle.
   task automatic cmd(input logic [1:0] op, input logic dir, input logic [3:0] tgt);
      cmd_valid  = 1'b1;
      cmd_op     = op;
      cmd_dir    = dir;
      cmd_target = tgt;
      cyc();
      cmd_valid  = 1'b0;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_dir = 1'b0; cmd_target = '0;
      #12;
      chk("rst_q", q, 4'h0);
      chk("rst_qn", qn, 4'hF);
      chk("rst_ready", cmd_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_wrap", wrap, 1'b0);
      chk("rst_ten", t_en, 4'h0);
      rst_n = 1'b1;
      cyc();

`ifndef TFF_PRESCALE_EN
      // Count up 0 -> 5
      cmd(2'b00, 1'b0, 4'h5);
      chk("up_busy", busy, 1'b1);
      chk("up_ten0", t_en, 4'h1);
      for (int k = 1; k <= 5; k++) begin
         cyc();
         chk($sformatf("up_q%0d", k), q, 32'(k));
      end
      chk("up_qn5", qn, 4'hA);
      chk("up_done", done, 1'b1);
      chk("up_ten_done", t_en, 4'h0);
      cyc();
      chk("up_busy_after", busy, 1'b0);
      chk("up_done_after", done, 1'b0);
      chk("up_hold", q, 4'h5);

      // CLEAR from IDLE, then bring q to 1
      cmd(2'b11, 1'b0, 4'h0);
      chk("clr_ready", cmd_ready, 1'b0);
      chk("clr_ten", t_en, 4'h5);
      cyc();
      chk("clr_q", q, 4'h0);
      chk("clr_ready_back", cmd_ready, 1'b1);
      cmd(2'b00, 1'b0, 4'h1);
      cyc();
      chk("to1_q", q, 4'h1);
      cyc();

      // Count down 1 -> 0 -> F -> E with wrap
      cmd(2'b00, 1'b1, 4'hE);
      chk("dn_ten1", t_en, 4'h1);
      chk("dn_wrap_n", wrap, 1'b0);
      cyc();
      chk("dn_q0", q, 4'h0);
      chk("dn_wrap", wrap, 1'b1);
      chk("dn_ten_wrap", t_en, 4'hF);
      cyc();
      chk("dn_qF", q, 4'hF);
      chk("dn_wrap_off", wrap, 1'b0);
      chk("dn_tenF", t_en, 4'h1);
      cyc();
      chk("dn_qE", q, 4'hE);
      chk("dn_done", done, 1'b1);
      cyc();
      chk("dn_idle", busy, 1'b0);

      // Pause / resume
      cmd(2'b11, 1'b0, 4'h0);
      cyc();
      cmd(2'b00, 1'b0, 4'hF);
      cyc(); cyc(); cyc();
      chk("pz_q3", q, 4'h3);
      cmd_valid = 1'b1; cmd_op = 2'b01;
      #1;
      chk("pz_stop_ten", t_en, 4'h0);
      cyc();
      cmd_valid = 1'b0;
      #1;
      chk("pz_busy", busy, 1'b0);
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk($sformatf("pz_hold%0d", k), q, 4'h3);
      end
      cmd(2'b10, 1'b0, 4'h0);
      chk("rs_busy", busy, 1'b1);
      chk("rs_q3", q, 4'h3);
      cyc();
      chk("rs_q4", q, 4'h4);
      cyc();
      chk("rs_q5", q, 4'h5);
      for (int k = 0; k < 6; k++) cyc();
      chk("rs_qB", q, 4'hB);
      cmd(2'b01, 1'b0, 4'h0);
      chk("pz2_qB", q, 4'hB);

      // CLEAR from PAUSE, then START with target equal to q
      cmd(2'b11, 1'b0, 4'h0);
      chk("pclr_ready", cmd_ready, 1'b0);
      chk("pclr_ten", t_en, 4'hB);
      cyc();
      chk("pclr_q", q, 4'h0);
      chk("pclr_ready_back", cmd_ready, 1'b1);
      chk("pclr_busy", busy, 1'b0);
      cmd(2'b00, 1'b0, 4'h0);
      chk("eq_done", done, 1'b1);
      chk("eq_ten", t_en, 4'h0);
      chk("eq_busy", busy, 1'b1);
      cyc();
      chk("eq_idle", busy, 1'b0);
      chk("eq_q", q, 4'h0);

      // Reset mid-run
      cmd(2'b00, 1'b0, 4'h9);
      cyc(); cyc();
      chk("mr_q2", q, 4'h2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_q", q, 4'h0);
      chk("mr_busy", busy, 1'b0);
      chk("mr_ready", cmd_ready, 1'b1);
`else
      // Prescaled count up 0 -> 2, four RUN cycles per step
      cmd(2'b00, 1'b0, 4'h2);
      chk("ps_busy", busy, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         cyc();
         chk($sformatf("ps_q_c%0d", k), q, (k < 4) ? 32'h0 : (k < 8) ? 32'h1 : 32'h2);
      end
      chk("ps_done", done, 1'b1);
      cyc();
      chk("ps_idle", busy, 1'b0);
      chk("ps_hold", q, 4'h2);
      cmd(2'b11, 1'b0, 4'h0);
      cyc();
      chk("ps_clr", q, 4'h0);
      cmd(2'b00, 1'b0, 4'h9);
      for (int k = 0; k < 5; k++) cyc();
      chk("ps_mr_q1", q, 4'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ps_mr_q", q, 4'h0);
      chk("ps_mr_busy", busy, 1'b0);
      chk("ps_mr_qn", qn, 4'hF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
